// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and datapath mux selects.
// alu_decoder consumes the same alu_op_t encoding.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_RDATA   = 2'b01,
    RES_ALURES  = 2'b10
  } result_src_t;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath/memory side (slave).
interface main_fsm_if;
  import main_fsm_pkg::*;

  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  alu_op_t     alu_op;
  src_a_t      alu_src_a;
  src_b_t      alu_src_b;
  result_src_t result_src;
  logic        adr_src;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        pc_write;
  logic        illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, reg_write, mem_write, pc_write, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, reg_write, mem_write, pc_write, illegal_op
  );

endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: Moore outputs decoded from one state register,
// plus a retired-instruction counter bumped on every completed instruction.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  main_fsm_if.master       bus,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  state_t state_next;
  logic   count_en;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_next;
      if (count_en) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next     = state;
    count_en       = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.result_src = RES_ALUOUT;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALURES;
        bus.ir_write   = bus.mem_ready;
        pc_update      = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            bus.illegal_op = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        state_next    = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_RDATA;
        bus.reg_write  = 1'b1;
        state_next     = S_FETCH;
        count_en       = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_FETCH;
          count_en   = 1'b1;
        end
      end
      S_EXECR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_op    = ALU_FUNCT;
        state_next    = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALU_FUNCT;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_next    = S_FETCH;
        count_en      = 1'b1;
      end
      S_JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        pc_update     = 1'b1;
        state_next    = S_ALUWB;
      end
      S_BEQ: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_op    = ALU_SUB;
        branch        = 1'b1;
        state_next    = S_FETCH;
        count_en      = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    bus.pc_write = pc_update | (branch & bus.zero);
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RISC-V core, producing the `ALUOp` code consumed by `alu_decoder`.

- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives all datapath mux selects and write enables as Moore outputs of the current state.
- Holds in memory states until the memory handshake completes.
- Sits beside `alu_decoder` in the control unit; both are instantiated at the core top level.

## Interface

**Parameters**
- `CNT_W`, 32: width of the retired-instruction counter.

**Ports**
- `clk`  in  1: core clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `op`  in  7: instruction opcode from the instruction register; stable from DECODE onward.
- `zero`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `alu_op`  out  2: to `alu_decoder`. Encoding: 00 add, 01 sub/branch, 10 funct-decoded.
- `alu_src_a`  out  2: 00 PC, 01 OldPC, 10 rs1 data.
- `alu_src_b`  out  2: 00 rs2 data, 01 immediate, 10 constant 4.
- `result_src`  out  2: 00 ALUOut register, 01 read data, 10 ALUResult.
- `adr_src`  out  1: memory address select. 0 PC, 1 Result.
- `ir_write`, `reg_write`, `mem_write`  out  1 each: write enables.
- `pc_write`  out  1: `pc_update | (branch & zero)`, combinational.
- `illegal_op`  out  1: high in DECODE when `op` is unsupported.
- `retired`  out  CNT_W: count of completed instructions.

## Operation

**Outputs and defaults**
- One state register; every output is decoded from the state.
- `mem_ready` gates IRWrite/PCUpdate in FETCH.
- `pc_write` additionally depends on `zero`.
- Any output not listed for a state is 0.

**States**
- FETCH: adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. `ir_write` and `pc_update` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: src_a=01, src_b=01, alu_op=00. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → FETCH with `illegal_op`=1. The instruction is not counted.
- MEMADR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD if `op`=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH and counts the instruction.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held until `mem_ready`. Then goes to FETCH and counts the instruction.
- EXECR: src_a=10, src_b=00, alu_op=10. Goes to ALUWB.
- EXECI: src_a=10, src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH and counts the instruction.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. Goes to FETCH and counts the instruction.

**Counter**
- `retired` increments by 1 on each counted transition into FETCH.
- Wraps modulo 2^CNT_W.

## Timing

**Reset**
- Asserting `rst`=0 immediately forces FETCH and `retired`=0, even mid-instruction or in a wait state.
- Outputs during reset are the FETCH values; `ir_write`/`pc_write` follow `mem_ready`.
- The first fetch begins on the first edge after deassertion.

**Latency with `mem_ready` high in the same cycle as each access**
- beq: 3 cycles
- R-type, I-type, sw, jal: 4 cycles
- lw: 5 cycles

**Memory wait states**
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Outputs hold for the whole wait.
- `mem_write` stays asserted through a MEMWRITE wait and deasserts on the cycle after `mem_ready`.

**Branch**
- In BEQ, `pc_write` equals `zero` in that same cycle.

## Structure

**Shared package**
- State encoding (11 states, 4 bits).
- Opcode constants.
- `alu_op`, `alu_src_a/b`, `result_src` encodings; `alu_decoder` uses the same `alu_op` encoding.

**Sub-modules**
- None. One sequential block holds the state and counter; one combinational block produces next state and outputs.

## Test plan

- Reset, then R-type (`op`=0110011), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB. `alu_op`=10 in EXECR; `reg_write`=1 in ALUWB only; `retired`=1.
- lw with `mem_ready`=0 for 2 cycles in MEMREAD → 7 cycles total; `result_src`=01 and `reg_write`=1 in MEMWB; `adr_src`=1 throughout MEMREAD.
- beq with `zero`=1, then again with `zero`=0 → `pc_write`=1 and 0 respectively in BEQ; `alu_op`=01; each takes 3 cycles.
- sw with `mem_ready` low for 3 cycles → `mem_write` high for 4 consecutive cycles, then FETCH; `retired` increments once.
- `op`=1111111 → `illegal_op`=1 for one cycle in DECODE, then FETCH; `retired` unchanged.
- Assert `rst` during MEMREAD wait → FETCH immediately, `retired`=0, `reg_write`=0. Also preload `retired` to 2^CNT_W−1 via a short-CNT_W build → next count reads 0.
